// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - instruction fields, status and datapath enables around the multicycle controller
interface multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       pc_en;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       imm_zext;
  logic [2:0] alu_ctrl;
  logic       reg_dest;
  logic       mem_to_reg;
  logic       reg_write;
  logic       illegal;

  modport master (
    output op, funct, zero, mem_ready,
    input  mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
           imm_zext, alu_ctrl, reg_dest, mem_to_reg, reg_write, illegal
  );

  modport slave (
    input  op, funct, zero, mem_ready,
    output mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
           imm_zext, alu_ctrl, reg_dest, mem_to_reg, reg_write, illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - control FSM sequencing the shared multicycle MIPS datapath
module multicycle_controller (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.slave bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE,
    ALUWB, BRANCH, ADDIEX, ORIEX, IMMWB, JUMP
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [2:0] alu_ctrl;
    logic       reg_dest;
    logic       mem_to_reg;
    logic       reg_write;
  } moore_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state;
  moore_t     mo;
  logic       op_valid;
  logic       funct_valid;
  logic [2:0] funct_alu;

  always_comb begin
    op_valid = 1'b0;
    case (bus.op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J: op_valid = 1'b1;
      default: op_valid = 1'b0;
    endcase
  end

  always_comb begin
    funct_valid = 1'b1;
    funct_alu   = ALU_ADD;
    case (bus.funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_valid = 1'b0;
    endcase
  end

  function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                        input logic mem_ready, input logic funct_ok);
    state_t n;
    n = FETCH;
    case (s)
      FETCH:   n = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW:   n = MEMADR;
          OP_RTYPE:       n = EXECUTE;
          OP_BEQ, OP_BNE: n = BRANCH;
          OP_ADDI:        n = ADDIEX;
          OP_ORI:         n = ORIEX;
          OP_J:           n = JUMP;
          default:        n = FETCH;
        endcase
      end
      MEMADR:  n = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   n = mem_ready ? MEMWB : MEMRD;
      MEMWR:   n = mem_ready ? FETCH : MEMWR;
      EXECUTE: n = funct_ok ? ALUWB : FETCH;
      ADDIEX:  n = IMMWB;
      ORIEX:   n = IMMWB;
      default: n = FETCH;
    endcase
    return n;
  endfunction

  // Decoded for the state being entered so the datapath controls come straight from flops.
  function automatic moore_t moore_out(input state_t s, input logic [2:0] falu);
    moore_t m;
    m = '0;
    case (s)
      FETCH:   begin m.mem_req = 1'b1; m.alu_src_b = 2'b01; m.alu_ctrl = ALU_ADD; end
      DECODE:  begin m.alu_src_b = 2'b11; m.alu_ctrl = ALU_ADD; end
      MEMADR:  begin m.alu_src_a = 1'b1; m.alu_src_b = 2'b10; m.alu_ctrl = ALU_ADD; end
      MEMRD:   begin m.mem_req = 1'b1; m.iord = 1'b1; end
      MEMWB:   begin m.reg_write = 1'b1; m.mem_to_reg = 1'b1; end
      MEMWR:   begin m.mem_req = 1'b1; m.mem_write = 1'b1; m.iord = 1'b1; end
      EXECUTE: begin m.alu_src_a = 1'b1; m.alu_ctrl = falu; end
      ALUWB:   begin m.reg_write = 1'b1; m.reg_dest = 1'b1; end
      BRANCH:  begin m.alu_src_a = 1'b1; m.alu_ctrl = ALU_SUB; m.pc_src = 2'b01; end
      ADDIEX:  begin m.alu_src_a = 1'b1; m.alu_src_b = 2'b10; m.alu_ctrl = ALU_ADD; end
      ORIEX:   begin m.alu_src_a = 1'b1; m.alu_src_b = 2'b10; m.imm_zext = 1'b1; m.alu_ctrl = ALU_OR; end
      IMMWB:   m.reg_write = 1'b1;
      JUMP:    m.pc_src = 2'b10;
      default: m = '0;
    endcase
    return m;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      mo    <= moore_out(FETCH, ALU_ADD);
    end else begin
      state <= next_state(state, bus.op, bus.mem_ready, funct_valid);
      mo    <= moore_out(next_state(state, bus.op, bus.mem_ready, funct_valid), funct_alu);
    end
  end

  // Strobes are masked by reset combinationally so nothing fires in the cycle reset is sampled.
  assign bus.mem_req    = mo.mem_req & ~reset;
  assign bus.mem_write  = mo.mem_write & ~reset;
  assign bus.reg_write  = mo.reg_write & ~reset;
  assign bus.iord       = mo.iord;
  assign bus.pc_src     = mo.pc_src;
  assign bus.alu_src_a  = mo.alu_src_a;
  assign bus.alu_src_b  = mo.alu_src_b;
  assign bus.imm_zext   = mo.imm_zext;
  assign bus.alu_ctrl   = mo.alu_ctrl;
  assign bus.reg_dest   = mo.reg_dest;
  assign bus.mem_to_reg = mo.mem_to_reg;

  assign bus.ir_write = ~reset & (state == FETCH) & bus.mem_ready;
  assign bus.pc_en    = ~reset & (((state == FETCH) & bus.mem_ready) |
                                  ((state == BRANCH) & (bus.zero ^ (bus.op == OP_BNE))) |
                                  (state == JUMP));
  assign bus.illegal  = ~reset & (((state == DECODE) & ~op_valid) |
                                  ((state == EXECUTE) & ~funct_valid));
endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();
  multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [2:0] alu_ctrl;
    logic       reg_dest;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
  } ctl_t;

  typedef enum int {B_FETCH, B_DECODE, B_MEMADR, B_MEMRD, B_MEMWB, B_MEMWR, B_EXEC,
                    B_ALUWB, B_BRANCH, B_ADDIEX, B_ORIEX, B_IMMWB, B_JUMP} bst_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         fst;
    int         mst;
    int         lat;
    bit         has3;
    logic [2:0] alu3;
    logic       pcen3;
    logic       zext3;
    int         ill;
    int         rw;
    int         mw;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  bst_t mstate;
  ctl_t sb[$];

  function automatic bit funct_ok(input logic [5:0] f);
    return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic ctl_t ref_out(input bst_t s, input logic [5:0] o, input logic [5:0] f,
                                   input logic z, input logic mr, input logic rst);
    ctl_t c;
    c = '0;
    case (s)
      B_FETCH:  begin c.mem_req = 1; c.alu_src_b = 2'b01; c.alu_ctrl = 3'b010; c.ir_write = mr; c.pc_en = mr; end
      B_DECODE: begin
        c.alu_src_b = 2'b11; c.alu_ctrl = 3'b010;
        c.illegal = !(o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                6'b001000, 6'b001101, 6'b000010});
      end
      B_MEMADR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_ctrl = 3'b010; end
      B_MEMRD:  begin c.mem_req = 1; c.iord = 1; end
      B_MEMWB:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      B_MEMWR:  begin c.mem_req = 1; c.mem_write = 1; c.iord = 1; end
      B_EXEC: begin
        c.alu_src_a = 1;
        case (f)
          6'b100010: c.alu_ctrl = 3'b110;
          6'b100100: c.alu_ctrl = 3'b000;
          6'b100101: c.alu_ctrl = 3'b001;
          6'b101010: c.alu_ctrl = 3'b111;
          default:   c.alu_ctrl = 3'b010;
        endcase
        c.illegal = !funct_ok(f);
      end
      B_ALUWB:  begin c.reg_write = 1; c.reg_dest = 1; end
      B_BRANCH: begin c.alu_src_a = 1; c.alu_ctrl = 3'b110; c.pc_src = 2'b01; c.pc_en = (o == 6'b000100) ? z : ~z; end
      B_ADDIEX: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_ctrl = 3'b010; end
      B_ORIEX:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.imm_zext = 1; c.alu_ctrl = 3'b001; end
      B_IMMWB:  c.reg_write = 1;
      B_JUMP:   begin c.pc_src = 2'b10; c.pc_en = 1; end
      default:  c = '0;
    endcase
    if (rst) begin
      c.pc_en = 0; c.ir_write = 0; c.reg_write = 0; c.mem_req = 0; c.mem_write = 0; c.illegal = 0;
    end
    return c;
  endfunction

  function automatic bst_t ref_next(input bst_t s, input logic [5:0] o, input logic [5:0] f,
                                    input logic mr, input logic rst);
    if (rst) return B_FETCH;
    case (s)
      B_FETCH:  return mr ? B_DECODE : B_FETCH;
      B_DECODE: begin
        if (o == 6'b100011 || o == 6'b101011) return B_MEMADR;
        if (o == 6'b000000) return B_EXEC;
        if (o == 6'b000100 || o == 6'b000101) return B_BRANCH;
        if (o == 6'b001000) return B_ADDIEX;
        if (o == 6'b001101) return B_ORIEX;
        if (o == 6'b000010) return B_JUMP;
        return B_FETCH;
      end
      B_MEMADR: return (o == 6'b101011) ? B_MEMWR : B_MEMRD;
      B_MEMRD:  return mr ? B_MEMWB : B_MEMRD;
      B_MEMWR:  return mr ? B_FETCH : B_MEMWR;
      B_EXEC:   return funct_ok(f) ? B_ALUWB : B_FETCH;
      B_ADDIEX, B_ORIEX: return B_IMMWB;
      default:  return B_FETCH;
    endcase
  endfunction

  function automatic ctl_t sample();
    ctl_t c;
    c.mem_req = bus.mem_req;     c.mem_write = bus.mem_write; c.iord = bus.iord;
    c.ir_write = bus.ir_write;   c.pc_en = bus.pc_en;         c.pc_src = bus.pc_src;
    c.alu_src_a = bus.alu_src_a; c.alu_src_b = bus.alu_src_b; c.imm_zext = bus.imm_zext;
    c.alu_ctrl = bus.alu_ctrl;   c.reg_dest = bus.reg_dest;   c.mem_to_reg = bus.mem_to_reg;
    c.reg_write = bus.reg_write; c.illegal = bus.illegal;
    return c;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: drive inputs just after the edge, predict, compare on the falling edge.
  task automatic cycle(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic mr, input logic rst, output ctl_t a);
    ctl_t e, m;
    bus.op = o; bus.funct = f; bus.zero = z; bus.mem_ready = mr; reset = rst;
    sb.push_back(ref_out(mstate, o, f, z, mr, rst));
    @(negedge clk);
    a = sample();
    e = sb.pop_front();
    m = '1;
    if (rst) begin
      m = '0;
      m.pc_en = 1; m.ir_write = 1; m.reg_write = 1; m.mem_req = 1; m.mem_write = 1; m.illegal = 1;
    end
    n_cmp++;
    if (((a ^ e) & m) != '0) begin
      n_bad++;
      $display("FAIL ctl state=%0d op=%b funct=%b: got %h expected %h", mstate, o, f, a, e);
    end
    mstate = ref_next(mstate, o, f, mr, rst);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input vec_t v);
    int   fst, mst, lat, post, n_ill, n_rw, n_mw, n_irw;
    bit   fetched, done, got3;
    ctl_t a, third;
    logic mr;
    fst = v.fst; mst = v.mst; lat = 0; post = 0;
    n_ill = 0; n_rw = 0; n_mw = 0; n_irw = 0;
    fetched = 0; done = 0; got3 = 0; third = '0;
    for (int k = 0; k < 40; k++) begin
      if (mstate == B_FETCH) begin
        mr = (fst > 0) ? 1'b0 : 1'b1;
        if (fst > 0) fst--;
      end else if (mstate == B_MEMRD || mstate == B_MEMWR) begin
        mr = (mst > 0) ? 1'b0 : 1'b1;
        if (mst > 0) mst--;
      end else begin
        mr = 1'($urandom_range(0, 1));
      end
      cycle(v.op, v.funct, v.zero, mr, 1'b0, a);
      lat++;
      n_ill += int'(a.illegal); n_rw += int'(a.reg_write);
      n_mw += int'(a.mem_write); n_irw += int'(a.ir_write);
      if (fetched) begin
        post++;
        if (post == 2) begin third = a; got3 = 1; end
      end
      if (a.ir_write) fetched = 1;
      if (fetched && bus.mem_req && !bus.iord && bus.alu_src_b == 2'b01 && !bus.alu_src_a) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: no return to FETCH within 40 cycles", v.name);
    end
    chk({v.name, " latency"}, lat, v.lat);
    chk({v.name, " illegal pulses"}, n_ill, v.ill);
    chk({v.name, " reg_write cycles"}, n_rw, v.rw);
    chk({v.name, " mem_write cycles"}, n_mw, v.mw);
    chk({v.name, " ir_write cycles"}, n_irw, 1);
    if (v.has3) begin
      chk({v.name, " third-cycle seen"}, int'(got3), 1);
      chk({v.name, " alu_ctrl"}, int'(third.alu_ctrl), int'(v.alu3));
      chk({v.name, " pc_en"}, int'(third.pc_en), int'(v.pcen3));
      chk({v.name, " imm_zext"}, int'(third.imm_zext), int'(v.zext3));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[16];
    ctl_t a;
    vt[0]  = '{"add",    6'b000000, 6'b100000, 1'b0, 0, 0, 4,  1'b1, 3'b010, 1'b0, 1'b0, 0, 1, 0};
    vt[1]  = '{"sub",    6'b000000, 6'b100010, 1'b0, 0, 0, 4,  1'b1, 3'b110, 1'b0, 1'b0, 0, 1, 0};
    vt[2]  = '{"and",    6'b000000, 6'b100100, 1'b0, 0, 0, 4,  1'b1, 3'b000, 1'b0, 1'b0, 0, 1, 0};
    vt[3]  = '{"or",     6'b000000, 6'b100101, 1'b0, 0, 0, 4,  1'b1, 3'b001, 1'b0, 1'b0, 0, 1, 0};
    vt[4]  = '{"slt",    6'b000000, 6'b101010, 1'b0, 0, 0, 4,  1'b1, 3'b111, 1'b0, 1'b0, 0, 1, 0};
    vt[5]  = '{"lw_stl", 6'b100011, 6'b000000, 1'b0, 2, 3, 10, 1'b1, 3'b010, 1'b0, 1'b0, 0, 1, 0};
    vt[6]  = '{"lw",     6'b100011, 6'b000000, 1'b0, 0, 0, 5,  1'b1, 3'b010, 1'b0, 1'b0, 0, 1, 0};
    vt[7]  = '{"sw_stl", 6'b101011, 6'b000000, 1'b0, 0, 2, 6,  1'b1, 3'b010, 1'b0, 1'b0, 0, 0, 3};
    vt[8]  = '{"beq_t",  6'b000100, 6'b000000, 1'b1, 0, 0, 3,  1'b1, 3'b110, 1'b1, 1'b0, 0, 0, 0};
    vt[9]  = '{"beq_n",  6'b000100, 6'b000000, 1'b0, 0, 0, 3,  1'b1, 3'b110, 1'b0, 1'b0, 0, 0, 0};
    vt[10] = '{"bne_t",  6'b000101, 6'b000000, 1'b0, 0, 0, 3,  1'b1, 3'b110, 1'b1, 1'b0, 0, 0, 0};
    vt[11] = '{"bne_n",  6'b000101, 6'b000000, 1'b1, 0, 0, 3,  1'b1, 3'b110, 1'b0, 1'b0, 0, 0, 0};
    vt[12] = '{"addi",   6'b001000, 6'b000000, 1'b0, 0, 0, 4,  1'b1, 3'b010, 1'b0, 1'b0, 0, 1, 0};
    vt[13] = '{"ori",    6'b001101, 6'b000000, 1'b0, 1, 0, 5,  1'b1, 3'b001, 1'b0, 1'b1, 0, 1, 0};
    vt[14] = '{"j",      6'b000010, 6'b000000, 1'b0, 0, 0, 3,  1'b1, 3'b000, 1'b1, 1'b0, 0, 0, 0};
    vt[15] = '{"bad_op", 6'b111111, 6'b000000, 1'b0, 0, 0, 2,  1'b0, 3'b000, 1'b0, 1'b0, 1, 0, 0};

    reset = 1'b1; bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    mstate = B_FETCH;
    @(posedge clk); #1;
    cycle(6'b0, 6'b0, 1'b0, 1'b1, 1'b1, a);
    cycle(6'b0, 6'b0, 1'b0, 1'b1, 1'b1, a);

    // First post-reset cycle, held in FETCH by mem_ready=0.
    cycle(6'b001000, 6'b0, 1'b0, 1'b0, 1'b0, a);
    chk("post-reset mem_req", int'(a.mem_req), 1);
    chk("post-reset iord", int'(a.iord), 0);
    chk("post-reset alu_src_b", int'(a.alu_src_b), 1);
    chk("post-reset alu_ctrl", int'(a.alu_ctrl), 2);
    chk("stall ir_write", int'(a.ir_write), 0);
    chk("stall pc_en", int'(a.pc_en), 0);

    // ADDI interrupted by reset while in IMMWB: the register write must be suppressed.
    cycle(6'b001000, 6'b0, 1'b0, 1'b1, 1'b0, a);
    cycle(6'b001000, 6'b0, 1'b0, 1'b1, 1'b0, a);
    cycle(6'b001000, 6'b0, 1'b0, 1'b1, 1'b0, a);
    cycle(6'b001000, 6'b0, 1'b0, 1'b1, 1'b1, a);
    chk("reset in IMMWB reg_write", int'(a.reg_write), 0);
    cycle(6'b001000, 6'b0, 1'b0, 1'b1, 1'b1, a);
    cycle(6'b001000, 6'b0, 1'b0, 1'b0, 1'b0, a);
    chk("after reset mem_req", int'(a.mem_req), 1);
    chk("after reset iord", int'(a.iord), 0);

    // SW stalled in MEMWR, then reset during the wait.
    cycle(6'b101011, 6'b0, 1'b0, 1'b1, 1'b0, a);
    cycle(6'b101011, 6'b0, 1'b0, 1'b1, 1'b0, a);
    cycle(6'b101011, 6'b0, 1'b0, 1'b1, 1'b0, a);
    cycle(6'b101011, 6'b0, 1'b0, 1'b0, 1'b0, a);
    chk("MEMWR wait mem_write", int'(a.mem_write), 1);
    chk("MEMWR wait iord", int'(a.iord), 1);
    cycle(6'b101011, 6'b0, 1'b0, 1'b0, 1'b1, a);
    chk("reset in MEMWR mem_write", int'(a.mem_write), 0);
    chk("reset in MEMWR mem_req", int'(a.mem_req), 0);
    cycle(6'b101011, 6'b0, 1'b0, 1'b0, 1'b0, a);
    chk("FETCH after MEMWR reset mem_req", int'(a.mem_req), 1);
    chk("FETCH after MEMWR reset mem_write", int'(a.mem_write), 0);
    chk("FETCH after MEMWR reset iord", int'(a.iord), 0);

    for (int i = 0; i < 16; i++) run_instr(vt[i]);

    // R-type with an undecoded funct: illegal in EXECUTE, never a register write.
    begin
      vec_t bf;
      bf = '{"bad_funct", 6'b000000, 6'b000000, 1'b0, 0, 0, 3, 1'b0, 3'b000, 1'b0, 1'b0, 1, 0, 0};
      run_instr(bf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle MIPS core. It sequences a shared datapath (one ALU, one unified instruction/data memory port, the register file, and the PC/IR/A/B/ALUOut registers) through fetch, decode, execute, memory and writeback steps. It handles R-type, LW, SW, BEQ, BNE, ADDI, J and ORI, and stalls on a memory-ready handshake. It replaces the single-cycle main/ALU decoders and sits between the instruction register and the datapath enables.

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; forces state FETCH
- op  in  6  IR[31:26], registered instruction opcode
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, valid in the BRANCH state
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access requested this cycle
- mem_write  out  1  access is a store (qualified by mem_req)
- iord  out  1  0 = address from PC, 1 = address from ALUOut
- ir_write  out  1  load IR from memory read data
- pc_en  out  1  PC load enable
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target {PC[31:28], IR[25:0], 00}
- alu_src_a  out  1  0 = PC, 1 = A register
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- imm_zext  out  1  replace sign-ext imm with zero-ext imm on alu_src_b = 10
- alu_ctrl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- reg_dest  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = memory data register
- reg_write  out  1  register file write enable
- illegal  out  1  one-cycle pulse on an undecoded opcode or funct

## Operation
- Moore FSM. Outputs are decoded from the state, except that pc_en, ir_write and illegal are also qualified by inputs as noted below. Unlisted outputs are 0 in every state.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=add, pc_src=00.
  - When mem_ready=1: ir_write=1 and pc_en=1, then go to DECODE.
  - Otherwise hold in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=add, precomputing the branch target into ALUOut. Next state by op:
  - 100011 or 101011 → MEMADR
  - 000000 → EXECUTE
  - 000100 or 000101 → BRANCH
  - 001000 → ADDIEX
  - 001101 → ORIEX
  - 000010 → JUMP
  - any other op → FETCH with illegal=1
- MEMADR: alu_src_a=1, alu_src_b=10, add. Go to MEMRD for LW, MEMWR for SW.
- MEMRD: mem_req=1, iord=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: reg_write=1, reg_dest=0, mem_to_reg=1. Go to FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1. Hold until mem_ready=1, then go to FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00.
  - alu_ctrl from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Valid funct → ALUWB.
  - Any other funct → FETCH with illegal=1; no register write occurs.
- ALUWB: reg_write=1, reg_dest=1, mem_to_reg=0. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01.
  - pc_en = zero for BEQ (op 000100).
  - pc_en = ~zero for BNE (op 000101).
  - Go to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, add. Go to IMMWB.
- ORIEX: alu_src_a=1, alu_src_b=10, imm_zext=1, or. Go to IMMWB.
- IMMWB: reg_write=1, reg_dest=0, mem_to_reg=0. Go to FETCH.
- JUMP: pc_src=10, pc_en=1. Go to FETCH.
- The controller holds no copy of op. op must stay stable from DECODE until the instruction returns to FETCH; this is guaranteed because ir_write is asserted only in FETCH.

## Timing
- Reset: sampled on a rising edge, it loads FETCH.
  - While reset=1, pc_en, ir_write, reg_write, mem_req, mem_write and illegal are forced to 0.
  - In the first cycle after reset deasserts, outputs take their FETCH values.
- Reset asserted mid-instruction (including during a memory wait) abandons the instruction. No write strobe is asserted in the reset cycle.
- Latency with mem_ready held at 1, counted in cycles from entering FETCH back to FETCH:
  - BEQ, BNE, J: 3
  - R-type, ADDI, ORI, SW: 4
  - LW: 5
  - Illegal opcode: 2
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. During a wait, mem_req, mem_write and iord hold stable, and ir_write and pc_en stay 0.
- mem_ready is ignored outside the three memory states.
- mem_req deasserts in the cycle after the cycle in which mem_ready=1 is seen.
- Unreachable state encodings return to FETCH on the next edge, with all strobes 0.

## Test plan
- Reset: assert reset for 2 cycles from a random state → state FETCH, all strobes 0 during reset. First post-reset cycle: mem_req=1, iord=0, alu_src_b=01, alu_ctrl=010.
- R-type: op=000000, funct=100010, mem_ready=1 → states FETCH, DECODE, EXECUTE, ALUWB. alu_ctrl=110 in EXECUTE; reg_write=1 with reg_dest=1 only in ALUWB; back in FETCH on cycle 5. Repeat for add, and, or, slt, checking each alu_ctrl code.
- LW with stall: mem_ready=0 for 2 cycles in FETCH and 3 cycles in MEMRD → total 10 cycles. ir_write and pc_en are 1 only on the FETCH completion cycle; mem_to_reg=1 and reg_write=1 in MEMWB. SW → mem_write=1, iord=1, no reg_write.
- Branches: BEQ with zero=1 → pc_en=1, pc_src=01 in BRANCH. BEQ with zero=0 → pc_en=0. BNE with zero=0 → pc_en=1; BNE with zero=1 → pc_en=0.
- Immediates and jump:
  - ORI → imm_zext=1 and alu_ctrl=001 in ORIEX.
  - ADDI → imm_zext=0 and alu_ctrl=010.
  - J → pc_src=10 and pc_en=1 in the third cycle.
- Illegal: op=111111 → illegal=1 for one cycle in DECODE, next state FETCH, no write strobes. R-type with funct=000000 → illegal=1 in EXECUTE, reg_write never asserted. Reset asserted during a MEMWR wait → mem_write drops the same cycle and FETCH follows.
